claa_pipe: RTL
==============

# claa_pipe

- Parametrised, pipelined carry-lookahead adder/subtractor; the multi-width successor of the team's 4-bit combinational CLAA.
- Built from 4-bit lookahead groups. Each group's carry-out is registered once per stage, so the clock period depends on one group, not on the full width.
- Accepts one operation per cycle under a valid/ready handshake with backpressure.
- Sits in the EXP datapath as the shared arithmetic unit feeding the ALU result mux.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4
- STAGES, derived WIDTH/4, number of pipeline stages (localparam, not overridable)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  pipeline can accept this cycle
- X  in  WIDTH  operand A
- Y  in  WIDTH  operand B
- C0  in  1  carry-in (add) / borrow-in (sub)
- SUB  in  1  0: F = X+Y+C0; 1: F = X−Y−C0
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- F  out  WIDTH  sum/difference
- C4  out  1  carry-out of MSB; in sub mode, 1 means no borrow
- V  out  1  signed overflow (only when CLAA_OVF_EN is defined)

## Operation
- Effective operands: Yeff = SUB ? ~Y : Y; cin = C0 ^ SUB.
- Transfer condition: in_valid && in_ready. SUB and C0 are captured with the operands.
- Stage k (k = 0..STAGES-1):
  - Computes group k (bits 4k+3:4k) with one cla4_group instance.
  - Stage 0 uses cin; stage k>0 uses the carry registered by stage k-1.
- Operand skew: bits of group k are delayed k cycles before reaching their stage.
- Result deskew: the sum of group k is delayed STAGES-1-k further cycles.
- All group results of one operation therefore appear together at the output.
- Each stage has its own valid bit. The stage STAGES-1 register is the output register.
- Stall:
  - in_ready = !out_valid || out_ready.
  - When in_ready = 0, every pipeline register (data and valid) holds.
  - There are no bubbles-only advances; the whole pipe freezes as one.
- Bubbles: when in_valid = 0 and in_ready = 1, a 0 valid enters stage 0; data registers may load don't-care values.
- Arithmetic: all group arithmetic is modulo 2^WIDTH. C4 is the carry out of bit WIDTH-1.

## Timing
- Latency: an operation accepted at rising edge n drives out_valid/F/C4 after edge n+STAGES (e.g. 4 cycles for WIDTH=16), when not stalled.
- Throughput: 1 operation per cycle while out_ready = 1.
- Stall: each cycle with out_valid && !out_ready extends latency by exactly one cycle for every in-flight operation. Order is preserved and nothing is dropped or duplicated.
- F, C4 and V are stable while out_valid && !out_ready.
- Reset: on any edge with rst = 1:
  - all valid bits, F, C4 and V go to 0;
  - in_ready = 1 in the following cycle;
  - in-flight operations are discarded, including a transfer presented in the reset cycle.
- in_ready is combinational from out_valid/out_ready. There is no path from in_valid to in_ready.

## Configuration
- CLAA_OVF_EN defined:
  - Port V exists.
  - V = (X[MSB] == Yeff[MSB]) && (F[MSB] != X[MSB]).
  - The MSBs of X and Yeff are carried down the pipeline alongside the top group's data.
  - V is registered with F and resets to 0.
- CLAA_OVF_EN undefined: port V and its pipeline bits are absent; all other behaviour is identical.

## Structure
- Package claa_pkg:
  - GROUP_W = 4;
  - function n_stages(width) returning width/GROUP_W;
  - an elaboration check that WIDTH % GROUP_W == 0.
- Sub-module cla4_group: combinational 4-bit lookahead slice.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, and group P/G.
  - Equations: carries c1..c4 from g_i = a_i&b_i and p_i = a_i^b_i.
  - claa_pipe instantiates STAGES copies with a generate loop.

## Test plan
- WIDTH=16, add: X=0x0008, Y=0x0008, C0=0 → F=0x0010, C4=0, out_valid exactly 4 cycles after acceptance. Repeat with C0=1 → F=0x0011.
- Carry across all groups: X=0xFFFF, Y=0x0001, C0=0 → F=0x0000, C4=1. With CLAA_OVF_EN, X=0x7FFF, Y=0x0001 → F=0x8000, V=1.
- Subtract: SUB=1, X=5, Y=3, C0=0 → F=0x0002, C4=1. SUB=1, X=3, Y=5 → F=0xFFFE, C4=0. SUB=1, X=5, Y=3, C0=1 → F=0x0001.
- Back-to-back: 8 consecutive random operations with out_ready=1 → 8 results in order on 8 consecutive cycles, each matching a reference model.
- Backpressure: hold out_ready=0 for 3 cycles while the pipe is full → in_ready=0 for those cycles, F/C4 held, no loss. Release → remaining results emerge in order.
- Reset mid-operation: assert rst for 1 cycle with 3 operations in flight → out_valid=0, F=0, C4=0 on the next cycle, and none of the flushed results ever appears. Repeat at WIDTH=4 (latency 1) and WIDTH=32 (latency 8).

Source files
------------

// File: rtl/claa_pkg.sv
// claa_pkg: shared constants and elaboration helpers for the pipelined
// carry-lookahead adder/subtractor (claa_pipe) and its 4-bit group slice.
//   GROUP_W  : bits per lookahead group, one group per pipeline stage
//   n_stages : pipeline depth for a given operand width
//   width_ok : legal-width predicate used by the top-level elaboration check
package claa_pkg;

  localparam int unsigned GROUP_W = 4;

  // One lookahead group is resolved per stage.
  function automatic int unsigned n_stages(input int unsigned width);
    return width / GROUP_W;
  endfunction

  // Width must be a non-zero whole number of groups.
  function automatic bit width_ok(input int unsigned width);
    return (width >= GROUP_W) && ((width % GROUP_W) == 0);
  endfunction

endpackage

// File: rtl/claa_pipe_group.sv
// cla4_group: combinational 4-bit carry-lookahead slice.
//   a, b : group operands
//   ci   : carry into the group
//   s    : group sum
//   co   : carry out of the group
//   p, g : group propagate / generate
module cla4_group
  import claa_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               ci,
  output logic [GROUP_W-1:0] s,
  output logic               co,
  output logic               p,
  output logic               g
);

  logic [GROUP_W-1:0] g_bit;
  logic [GROUP_W-1:0] p_bit;
  logic [GROUP_W:0]   c;

  assign g_bit = a & b;
  assign p_bit = a ^ b;

  // Flat lookahead: every internal carry depends only on g/p and ci.
  assign c[0] = ci;
  assign c[1] = g_bit[0] | (p_bit[0] & ci);
  assign c[2] = g_bit[1] | (p_bit[1] & g_bit[0]) | (p_bit[1] & p_bit[0] & ci);
  assign c[3] = g_bit[2] | (p_bit[2] & g_bit[1]) | (p_bit[2] & p_bit[1] & g_bit[0])
              | (p_bit[2] & p_bit[1] & p_bit[0] & ci);

  assign g = g_bit[3] | (p_bit[3] & g_bit[2]) | (p_bit[3] & p_bit[2] & g_bit[1])
           | (p_bit[3] & p_bit[2] & p_bit[1] & g_bit[0]);
  assign p = &p_bit;
  assign c[4] = g | (p & ci);

  assign s  = p_bit ^ c[GROUP_W-1:0];
  assign co = c[GROUP_W];

endmodule

// File: rtl/claa_pipe.sv
// claa_pipe: pipelined carry-lookahead adder/subtractor, one 4-bit group per
// stage, valid/ready handshake with whole-pipe stall.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready combinational from output side)
//   X, Y, C0, SUB       : operands; SUB=0: F=X+Y+C0, SUB=1: F=X-Y-C0
//   out_valid/out_ready : result handshake
//   F, C4               : result and MSB carry-out (sub: 1 = no borrow)
//   V                   : signed overflow, present only when CLAA_OVF_EN is defined
// Optional feature macro: CLAA_OVF_EN
module claa_pipe
  import claa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             C0,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             C4
`ifdef CLAA_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int unsigned STAGES = n_stages(WIDTH);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("claa_pipe: WIDTH must be a non-zero multiple of the group width");
  end

  // Register index 0 is the operand capture register; index k+1 is the output
  // of stage k, so index STAGES is the output register.
  // d_q[k] holds resolved sum bits below group k and still-raw X bits from
  // group k upward: the operand skew and result deskew share one register.
  logic [WIDTH-1:0] d_q   [STAGES+1];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] d_nxt [STAGES];
  logic [STAGES:0]  vld_q;
  logic [STAGES:0]  c_q;
  logic [STAGES-1:0] grp_co;
  logic [STAGES-1:0] grp_p_unused;
  logic [STAGES-1:0] grp_g_unused;

  // Whole pipe advances together whenever the output slot is free or draining.
  assign in_ready = !vld_q[STAGES] || out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] GMASK = WIDTH'({GROUP_W{1'b1}}) << (GROUP_W * k);
    logic [GROUP_W-1:0] grp_s;

    cla4_group u_grp (
      .a  (d_q[k][GROUP_W*k +: GROUP_W]),
      .b  (b_q[k][GROUP_W*k +: GROUP_W]),
      .ci (c_q[k]),
      .s  (grp_s),
      .co (grp_co[k]),
      .p  (grp_p_unused[k]),
      .g  (grp_g_unused[k])
    );

    // Replace group k's operand bits with its sum; other bits pass through.
    assign d_nxt[k] = (d_q[k] & ~GMASK) | (WIDTH'(grp_s) << (GROUP_W * k));
  end

  // Pipeline registers: capture, per-stage data/carry/valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int unsigned k = 0; k <= STAGES; k++) d_q[k] <= '0;
      for (int unsigned k = 0; k < STAGES; k++)  b_q[k] <= '0;
    end else if (in_ready) begin
      vld_q  <= {vld_q[STAGES-1:0], in_valid};
      c_q    <= {grp_co, C0 ^ SUB};
      d_q[0] <= X;
      b_q[0] <= SUB ? ~Y : Y;
      for (int unsigned k = 0; k < STAGES; k++)  d_q[k+1] <= d_nxt[k];
      for (int unsigned k = 1; k < STAGES; k++)  b_q[k]   <= b_q[k-1];
    end
  end

  assign out_valid = vld_q[STAGES];
  assign F         = d_q[STAGES];
  assign C4        = c_q[STAGES];

`ifdef CLAA_OVF_EN
  // The top stage still holds raw X and Yeff MSBs, so overflow is formed there
  // and registered alongside F.
  logic ovf_nxt;
  logic ovf_q;

  assign ovf_nxt = (d_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                && (d_nxt[STAGES-1][WIDTH-1] != d_q[STAGES-1][WIDTH-1]);

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (in_ready) begin
      ovf_q <= ovf_nxt;
    end
  end

  assign V = ovf_q;
`endif

endmodule
